image_downsample: RTL and testbench
===================================

# image_downsample

Parametrised 2:1 image downsampler for the scale-space (octave) path. It accepts a raster-order pixel stream with coordinates and emits a half-width, half-height image as linear-address writes for the next octave's BRAM. Two modes are supported: plain decimation (keep the even/even pixel) and 2x2 box averaging through an internal half-line buffer. It also checks stream ordering, flags errors, and signals frame completion.

## Interface
Parameters:
- BIT_DEPTH, 8, pixel width in bits.
- OLD_WIDTH, 64, input image width; must be even and ≥ 2.
- OLD_HEIGHT, 64, input image height; must be even and ≥ 2.
- COORD_WIDTH, 8, width of the x/y coordinate inputs.
- Derived: NEW_WIDTH = OLD_WIDTH/2, NEW_HEIGHT = OLD_HEIGHT/2, ADDR_WIDTH = $clog2(NEW_WIDTH*NEW_HEIGHT).

Ports:
- Clocking and reset: one clock; reset is synchronous and active-high. The ports are named clk_in and rst_in.
- clk_in, input, 1, clock.
- rst_in, input, 1, synchronous active-high reset.
- mode_in, input, 1, 0 = decimate, 1 = 2x2 average; sampled only when pixel (0,0) is accepted.
- data_in, input, BIT_DEPTH, pixel value.
- data_x_in, input, COORD_WIDTH, pixel column.
- data_y_in, input, COORD_WIDTH, pixel row.
- data_valid_in, input, 1, pixel qualifier.
- data_out, output, BIT_DEPTH, downsampled pixel.
- data_addr_out, output, ADDR_WIDTH, equals (y>>1)*NEW_WIDTH + (x>>1).
- data_valid_out, output, 1, output qualifier.
- done_out, output, 1, one-cycle pulse on the last output pixel of a frame.
- busy_out, output, 1, high while a frame is in progress.
- error_out, output, 1, sticky ordering error flag.

## Operation
- Input is strict raster order: x runs 0..OLD_WIDTH-1, then y increments. Gaps in data_valid_in are allowed.
- The expected coordinate (exp_x, exp_y) is held internally. Each valid pixel is compared against it.
- States:
  - IDLE: expects (0,0). Accepting (0,0) latches the mode, sets exp = (1,0) and moves to RUN. Any other coordinate moves to ERR.
  - RUN: a matching pixel is processed and exp advances, wrapping x to 0 and incrementing y. A mismatch, or x ≥ OLD_WIDTH or y ≥ OLD_HEIGHT, moves to ERR and the pixel is dropped. Accepting (OLD_WIDTH-1, OLD_HEIGHT-1) moves to IDLE.
  - ERR: all inputs are ignored and no outputs are produced. Only rst_in exits this state.
- Decimate mode: an output is produced for every pixel with even x and even y. data_out = data_in.
- Average mode:
  - Even row: on even x, hold data_in in a pair register. On odd x, write pair + data_in (BIT_DEPTH+1 bits) to linebuf[x>>1]. linebuf holds NEW_WIDTH entries.
  - Odd row: on even x, hold data_in. On odd x, compute sum = linebuf[x>>1] + pair + data_in (BIT_DEPTH+2 bits) and output (sum + 2) >> 2, which rounds half up.
  - The result never overflows: the maximum is (4*(2^BIT_DEPTH-1)+2)>>2 = 2^BIT_DEPTH-1.
- Addresses are computed the same way in both modes, from the coordinates of the triggering pixel.
- busy_out = (state == RUN). error_out = (state == ERR).

## Timing
- Reset values: data_out = 0, data_addr_out = 0, data_valid_out = 0, done_out = 0, busy_out = 0, error_out = 0. State returns to IDLE and mode is cleared to 0.
- Latency is 1 cycle. A triggering pixel accepted at edge N produces data_valid_out high for exactly the cycle after edge N. data_valid_out is 0 in every other cycle.
- done_out is high in the same cycle as the data_valid_out of the final output pixel, at address NEW_WIDTH*NEW_HEIGHT-1.
- busy_out rises in the cycle after (0,0) is accepted and falls in the cycle after the last pixel is accepted.
- A new frame's (0,0) is accepted on the first valid cycle after returning to IDLE. There is no dead cycle.
- Reset mid-frame: all partial sums and the frame are discarded. Stale linebuf contents are harmless because every entry is rewritten before it is read.
- If rst_in and data_valid_in are high in the same cycle, rst_in wins and the pixel is dropped.
- The ERR transition takes effect at the edge that sees the bad pixel. error_out is high from the next cycle onward.

## Configuration
- Macro: DOWNSAMPLE_AVG_EN.
- Defined: averaging mode, linebuf and pair registers are compiled in, and mode_in is honoured.
- Undefined: mode_in is ignored, the block always decimates, and no line buffer or adders are generated. Ordering checks, done_out and busy_out are unchanged.

## Test plan
- Decimate, OLD_WIDTH=4, OLD_HEIGHT=4, pixel value = 4y+x, no gaps → 4 outputs: (0,0), (2,1), (8,2), (10,3) as (data, addr), each one cycle after its trigger. done_out pulses with addr 3.
- Average (macro defined), same image → 4 outputs: (3,0), (5,1), (11,2), (13,3). Check rounding with all four pixels = {0,0,0,2}: sum 2 gives output 1.
- Average with all pixels 255 and BIT_DEPTH=8 → every output is 255, with no overflow.
- Ordering error: feed (0,0), (1,0), then (3,0) → error_out is high from the next cycle and stays high. No outputs appear for any later pixels. After rst_in, a clean frame completes correctly.
- Back-to-back frames with random valid gaps, mode switched between frames → each frame uses the mode latched at its (0,0). busy_out is low for one cycle at most between frames.
- Reset asserted mid-frame at (2,1), then a full frame is fed → outputs are identical to a frame fed with no prior activity. All outputs are 0 during reset.

Source files
------------

// File: rtl/image_downsample_if.sv
// Pixel-stream and downsampled-write bus for image_downsample.
// slave = downsampler side, master = pixel source / output sink side.
interface image_downsample_if #(
  parameter int BIT_DEPTH   = 8,
  parameter int ADDR_WIDTH  = 10,
  parameter int COORD_WIDTH = 8
);
  logic                   mode_in;
  logic [BIT_DEPTH-1:0]   data_in;
  logic [COORD_WIDTH-1:0] data_x_in;
  logic [COORD_WIDTH-1:0] data_y_in;
  logic                   data_valid_in;
  logic [BIT_DEPTH-1:0]   data_out;
  logic [ADDR_WIDTH-1:0]  data_addr_out;
  logic                   data_valid_out;
  logic                   done_out;
  logic                   busy_out;
  logic                   error_out;

  modport slave (
    input  mode_in, data_in, data_x_in, data_y_in, data_valid_in,
    output data_out, data_addr_out, data_valid_out, done_out, busy_out, error_out
  );

  modport master (
    output mode_in, data_in, data_x_in, data_y_in, data_valid_in,
    input  data_out, data_addr_out, data_valid_out, done_out, busy_out, error_out
  );
endinterface

// File: rtl/image_downsample.sv
// 2:1 raster-stream downsampler (decimate, or 2x2 rounded average when
// DOWNSAMPLE_AVG_EN is defined) with stream-order checking and frame done/busy.
module image_downsample #(
  parameter int BIT_DEPTH   = 8,
  parameter int OLD_WIDTH   = 64,
  parameter int OLD_HEIGHT  = 64,
  parameter int COORD_WIDTH = 8
) (
  input logic            clk_in,
  input logic            rst_in,
  image_downsample_if.slave bus
);
  localparam int NEW_WIDTH  = OLD_WIDTH / 2;
  localparam int NEW_HEIGHT = OLD_HEIGHT / 2;
  localparam int ADDR_WIDTH = (NEW_WIDTH * NEW_HEIGHT > 1) ? $clog2(NEW_WIDTH * NEW_HEIGHT) : 1;
  localparam logic [ADDR_WIDTH-1:0]  LAST_ADDR = ADDR_WIDTH'(NEW_WIDTH * NEW_HEIGHT - 1);
  localparam logic [COORD_WIDTH-1:0] LAST_X    = COORD_WIDTH'(OLD_WIDTH - 1);
  localparam logic [COORD_WIDTH-1:0] LAST_Y    = COORD_WIDTH'(OLD_HEIGHT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_ERR} state_t;

  state_t                 state_q, state_d;
  logic [COORD_WIDTH-1:0] exp_x_q, exp_x_d;
  logic [COORD_WIDTH-1:0] exp_y_q, exp_y_d;
  logic [BIT_DEPTH-1:0]   data_q, data_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic                   valid_q, valid_d;
  logic                   done_q, done_d;

  logic                   pix_valid;
  logic                   coord_ok;
  logic                   take;
  logic                   avg_sel;
  logic [ADDR_WIDTH-1:0]  pix_addr;

  // A pixel presented together with reset is never processed.
  assign pix_valid = bus.data_valid_in & ~rst_in;
  assign coord_ok  = (bus.data_x_in == exp_x_q) && (bus.data_y_in == exp_y_q) &&
                     (bus.data_x_in <= LAST_X) && (bus.data_y_in <= LAST_Y);
  assign pix_addr  = ADDR_WIDTH'(ADDR_WIDTH'(bus.data_y_in >> 1) * ADDR_WIDTH'(NEW_WIDTH) +
                                 ADDR_WIDTH'(bus.data_x_in >> 1));

`ifdef DOWNSAMPLE_AVG_EN
  localparam int LB_AW = (NEW_WIDTH > 1) ? $clog2(NEW_WIDTH) : 1;

  logic                 mode_q, mode_d;
  logic [BIT_DEPTH-1:0] pair_q, pair_d;
  logic [BIT_DEPTH:0]   linebuf [NEW_WIDTH];
  logic [BIT_DEPTH:0]   ram_rd_q;
  logic [BIT_DEPTH:0]   lb_wdata;
  logic [LB_AW-1:0]     lb_addr;
  logic                 lb_we;
  logic                 lb_re;
  logic [BIT_DEPTH+1:0] sum;

  // The mode for pixel (0,0) comes straight from the input; later pixels use the latched copy.
  assign avg_sel = (state_q == ST_IDLE) ? bus.mode_in : mode_q;
  assign lb_addr = LB_AW'(bus.data_x_in >> 1);

  always_ff @(posedge clk_in) begin
    if (lb_we) begin
      linebuf[lb_addr] <= lb_wdata;
    end
    if (lb_re) begin
      ram_rd_q <= linebuf[lb_addr];
    end
  end
`else
  assign avg_sel = 1'b0;
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= ST_IDLE;
      exp_x_q <= '0;
      exp_y_q <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
`ifdef DOWNSAMPLE_AVG_EN
      mode_q  <= 1'b0;
      pair_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      exp_x_q <= exp_x_d;
      exp_y_q <= exp_y_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      done_q  <= done_d;
`ifdef DOWNSAMPLE_AVG_EN
      mode_q  <= mode_d;
      pair_q  <= pair_d;
`endif
    end
  end

  always_comb begin : next_state
    state_d = state_q;
    exp_x_d = exp_x_q;
    exp_y_d = exp_y_q;
    take    = 1'b0;
`ifdef DOWNSAMPLE_AVG_EN
    mode_d  = mode_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pix_valid) begin
          if (bus.data_x_in == '0 && bus.data_y_in == '0) begin
            take    = 1'b1;
            state_d = ST_RUN;
            exp_x_d = COORD_WIDTH'(1);
            exp_y_d = '0;
`ifdef DOWNSAMPLE_AVG_EN
            mode_d  = bus.mode_in;
`endif
          end else begin
            state_d = ST_ERR;
          end
        end
      end
      ST_RUN: begin
        if (pix_valid) begin
          if (coord_ok) begin
            take = 1'b1;
            if (exp_x_q == LAST_X) begin
              exp_x_d = '0;
              if (exp_y_q == LAST_Y) begin
                exp_y_d = '0;
                state_d = ST_IDLE;
              end else begin
                exp_y_d = exp_y_q + COORD_WIDTH'(1);
              end
            end else begin
              exp_x_d = exp_x_q + COORD_WIDTH'(1);
            end
          end else begin
            state_d = ST_ERR;
          end
        end
      end
      ST_ERR:  state_d = ST_ERR;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin : datapath
    data_d  = data_q;
    addr_d  = addr_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
`ifdef DOWNSAMPLE_AVG_EN
    pair_d   = pair_q;
    lb_we    = 1'b0;
    lb_re    = 1'b0;
    lb_wdata = {1'b0, pair_q} + {1'b0, bus.data_in};
    sum      = {2'b00, pair_q} + {2'b00, bus.data_in} + {1'b0, ram_rd_q} + (BIT_DEPTH+2)'(2);
`endif
    if (take) begin
      if (!avg_sel) begin
        if (!bus.data_x_in[0] && !bus.data_y_in[0]) begin
          valid_d = 1'b1;
          data_d  = bus.data_in;
          addr_d  = pix_addr;
        end
      end
`ifdef DOWNSAMPLE_AVG_EN
      else begin
        // Even rows fold horizontal pairs into linebuf; odd rows fetch that
        // entry on even x so the registered read is ready at the odd x.
        if (!bus.data_x_in[0]) begin
          pair_d = bus.data_in;
          lb_re  = bus.data_y_in[0];
        end else if (!bus.data_y_in[0]) begin
          lb_we = 1'b1;
        end else begin
          valid_d = 1'b1;
          data_d  = BIT_DEPTH'(sum >> 2);
          addr_d  = pix_addr;
        end
      end
`endif
      done_d = valid_d && (pix_addr == LAST_ADDR);
    end
  end

  assign bus.data_out       = data_q;
  assign bus.data_addr_out  = addr_q;
  assign bus.data_valid_out = valid_q;
  assign bus.done_out       = done_q;
  assign bus.busy_out       = (state_q == ST_RUN);
  assign bus.error_out      = (state_q == ST_ERR);
endmodule

// File: tb/tb_image_downsample.sv
// Randomised bench for image_downsample: a per-frame image model predicts every
// output (value, address, done, cycle) from the 2x2 block rules.
module tb_image_downsample;
  localparam int BD = 8;
  localparam int OW = 4;
  localparam int OH = 4;
  localparam int CW = 8;
  localparam int NW = OW / 2;
  localparam int NH = OH / 2;
  localparam int AW = $clog2(NW * NH);

  typedef struct {
    int edge_n;
    int data;
    int addr;
    int done;
  } out_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   edge_cnt = 0;
  int   n_checks = 0;
  int   n_err = 0;
  out_t act_q[$];
  out_t exp_q[$];
  int   img[OH][OW];
  int   acc_edge[OH][OW];

  always #5 clk = ~clk;

  image_downsample_if #(.BIT_DEPTH(BD), .ADDR_WIDTH(AW), .COORD_WIDTH(CW)) bus ();

  image_downsample #(
    .BIT_DEPTH(BD), .OLD_WIDTH(OW), .OLD_HEIGHT(OH), .COORD_WIDTH(CW)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .bus   (bus)
  );

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Capture every output beat with the edge that produced it.
  always @(negedge clk) begin
    if (bus.data_valid_out === 1'b1) begin
      act_q.push_back('{edge_cnt, int'(bus.data_out), int'(bus.data_addr_out), int'(bus.done_out)});
    end else if (bus.done_out === 1'b1) begin
      check("done_without_valid", 32'(bus.done_out), 32'd0);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.data_valid_in = 1'b0;
    end
  endtask

  task automatic drive_pixel(input int x, input int y, input int v, input int m,
                             input int max_gap, input bit chk_state);
    int g;
    g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    repeat (g) begin
      @(negedge clk);
      bus.data_valid_in = 1'b0;
    end
    @(negedge clk);
    if (chk_state) begin
      check("busy", 32'(bus.busy_out), (x == 0 && y == 0) ? 32'd0 : 32'd1);
      check("error", 32'(bus.error_out), 32'd0);
    end
    bus.data_in       = BD'(v);
    bus.data_x_in     = CW'(x);
    bus.data_y_in     = CW'(y);
    bus.mode_in       = m[0];
    bus.data_valid_in = 1'b1;
    if (x < OW && y < OH) acc_edge[y][x] = edge_cnt + 1;
  endtask

  task automatic fill_image(input int pattern);
    for (int y = 0; y < OH; y++) begin
      for (int x = 0; x < OW; x++) begin
        case (pattern)
          0:       img[y][x] = 4 * y + x;
          1:       img[y][x] = int'($urandom_range(255, 0));
          2:       img[y][x] = 255;
          default: img[y][x] = (y % 2 == 1 && x % 2 == 1) ? 2 : 0;
        endcase
      end
    end
  endtask

  task automatic predict_frame(input int m);
    int eff;
    int s;
`ifdef DOWNSAMPLE_AVG_EN
    eff = m;
`else
    eff = 0;
`endif
    for (int j = 0; j < NH; j++) begin
      for (int i = 0; i < NW; i++) begin
        out_t o;
        o.addr = j * NW + i;
        o.done = (o.addr == NW * NH - 1) ? 1 : 0;
        if (eff != 0) begin
          s = img[2*j][2*i] + img[2*j][2*i+1] + img[2*j+1][2*i] + img[2*j+1][2*i+1];
          o.data   = (s + 2) / 4;
          o.edge_n = acc_edge[2*j+1][2*i+1];
        end else begin
          o.data   = img[2*j][2*i];
          o.edge_n = acc_edge[2*j][2*i];
        end
        exp_q.push_back(o);
      end
    end
  endtask

  task automatic run_frame(input int m, input int pattern, input int max_gap);
    fill_image(pattern);
    for (int y = 0; y < OH; y++)
      for (int x = 0; x < OW; x++)
        drive_pixel(x, y, img[y][x], m, max_gap, 1'b1);
    predict_frame(m);
  endtask

  task automatic compare_outputs(input string tag);
    out_t a;
    out_t e;
    idle(3);
    check({tag, "_count"}, 32'(act_q.size()), 32'(exp_q.size()));
    while (act_q.size() > 0 && exp_q.size() > 0) begin
      a = act_q.pop_front();
      e = exp_q.pop_front();
      check({tag, "_addr"}, 32'(a.addr), 32'(e.addr));
      check({tag, "_data"}, 32'(a.data), 32'(e.data));
      check({tag, "_done"}, 32'(a.done), 32'(e.done));
      check({tag, "_cycle"}, 32'(a.edge_n), 32'(e.edge_n));
    end
    act_q.delete();
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data"},  32'(bus.data_out), 32'd0);
    check({tag, "_addr"},  32'(bus.data_addr_out), 32'd0);
    check({tag, "_valid"}, 32'(bus.data_valid_out), 32'd0);
    check({tag, "_done"},  32'(bus.done_out), 32'd0);
    check({tag, "_busy"},  32'(bus.busy_out), 32'd0);
    check({tag, "_error"}, 32'(bus.error_out), 32'd0);
  endtask

  initial begin
    bus.mode_in       = 1'b0;
    bus.data_in       = '0;
    bus.data_x_in     = '0;
    bus.data_y_in     = '0;
    bus.data_valid_in = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    run_frame(0, 0, 0);
    compare_outputs("decim_ramp");
    run_frame(1, 0, 0);
    compare_outputs("avg_ramp");
    run_frame(1, 3, 0);
    compare_outputs("avg_round");
    run_frame(1, 2, 2);
    compare_outputs("avg_max");

    // Ordering error: (0,0), (1,0), then (3,0).
    drive_pixel(0, 0, 7, 0, 0, 1'b1);
    drive_pixel(1, 0, 7, 0, 0, 1'b1);
    drive_pixel(3, 0, 7, 0, 0, 1'b1);
    idle(1);
    check("err_raised", 32'(bus.error_out), 32'd1);
    check("err_busy", 32'(bus.busy_out), 32'd0);
    act_q.delete();
    for (int i = 0; i < 6; i++) drive_pixel(i % OW, i / OW, 9, 0, 1, 1'b0);
    idle(3);
    check("err_sticky", 32'(bus.error_out), 32'd1);
    check("err_no_output", 32'(act_q.size()), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("err_reset");
    rst = 1'b0;
    act_q.delete();
    run_frame(0, 1, 1);
    compare_outputs("after_err");

    // Reset mid-frame, arriving together with pixel (2,1).
    fill_image(1);
    for (int idx = 0; idx < OW + 2; idx++)
      drive_pixel(idx % OW, idx / OW, img[idx / OW][idx % OW], 1, 0, 1'b1);
    @(negedge clk);
    rst               = 1'b1;
    bus.data_x_in     = CW'(2);
    bus.data_y_in     = CW'(1);
    bus.data_valid_in = 1'b1;
    @(negedge clk);
    check_reset_outputs("midreset");
    bus.data_valid_in = 1'b0;
    rst = 1'b0;
    act_q.delete();
    exp_q.delete();
    run_frame(1, 1, 1);
    compare_outputs("after_midreset");

    // Back-to-back frames, random gaps and modes, then gap-free with a mode switch.
    for (int f = 0; f < 4; f++) run_frame(int'($urandom_range(1, 0)), 1, 2);
    compare_outputs("b2b_rand");
    run_frame(0, 1, 0);
    run_frame(1, 1, 0);
    run_frame(0, 1, 0);
    compare_outputs("b2b_tight");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
